shift_right_deserializer: RTL and testbench

- Downstream consumer of the 8-bit shift-left serializer's `so` stream.
- The serializer sends MSB first. This block rebuilds parallel words from that stream.
- Completed words are held in a one-word output buffer with a valid/ready handshake toward the parallel datapath.
- Bit-frame alignment comes from an explicit `sync` strobe. Words completed while the buffer is still occupied are counted as overflow.

---
 rtl/shift_right_deserializer.sv | 80 ++++++++
 tb/tb_shift_right_deserializer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/shift_right_deserializer.sv
// shift_right_deserializer: MSB-first serial-to-parallel converter with valid/ready output buffer and sticky overflow.
// Optional even-parity trailer bit per frame when DESER_PARITY_EN is defined (adds parity_err output).
module shift_right_deserializer #(
  parameter int W  = 8,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          si,
  input  logic          si_en,
  input  logic          sync,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [CW-1:0] bit_cnt,
  output logic          ovf,
`ifdef DESER_PARITY_EN
  output logic          parity_err,
`endif
  input  logic          ovf_clr
);
`ifdef DESER_PARITY_EN
  localparam int FRAME = W + 1;
  localparam int SW    = W;
`else
  localparam int FRAME = W;
  localparam int SW    = W - 1;
`endif
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);
  logic [SW-1:0] sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  dout_q, dout_d, word;
  logic          valid_q, valid_d, ovf_q, ovf_d;
  logic          shift_en, last, load, drop;
`ifdef DESER_PARITY_EN
  logic          perr_q, perr_d;
  assign word   = sr_q;
  assign perr_d = load ? (^sr_q ^ si) : perr_q;
  assign parity_err = perr_q;
`else
  // Only W-1 bits are kept; the W-th bit is taken straight from si on completion.
  assign word = {sr_q, si};
`endif
  always_comb begin
    shift_en = si_en & ~sync;
    last     = shift_en & (cnt_q == LAST);
    load     = last & (~valid_q | dout_ready);
    drop     = last & valid_q & ~dout_ready;
    sr_d     = sync ? (si_en ? SW'(si) : '0) : shift_en ? SW'({sr_q, si}) : sr_q;
    cnt_d    = sync ? (si_en ? CW'(1) : '0) : last ? '0 : shift_en ? cnt_q + CW'(1) : cnt_q;
    dout_d   = load ? word : dout_q;
    valid_d  = load | (valid_q & ~dout_ready);
    ovf_d    = drop | (ovf_q & ~ovf_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end
`ifdef DESER_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end
`endif
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign bit_cnt    = cnt_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_shift_right_deserializer.sv
// tb_shift_right_deserializer: directed and random stimulus checked against an integer-level frame model.
module tb_shift_right_deserializer;
  localparam int W = 8;
`ifdef DESER_PARITY_EN
  localparam int CW = 4;
  localparam int FRAME = W + 1;
`else
  localparam int CW = 3;
  localparam int FRAME = W;
`endif
  logic clk, rst_n, si, si_en, sync, dout_ready, ovf_clr, dout_valid, ovf;
  logic [W-1:0] dout;
  logic [CW-1:0] bit_cnt;
`ifdef DESER_PARITY_EN
  logic parity_err;
`endif
  int checks, failures;
  int m_cnt, m_acc;
  logic [7:0] m_dout;
  bit m_valid, m_ovf, m_perr;
  shift_right_deserializer #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .si(si), .si_en(si_en), .sync(sync),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .bit_cnt(bit_cnt), .ovf(ovf),
`ifdef DESER_PARITY_EN
    .parity_err(parity_err),
`endif
    .ovf_clr(ovf_clr)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("bit_cnt", 32'(bit_cnt), 32'(m_cnt));
    chk("dout", 32'(dout), 32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("ovf", 32'(ovf), 32'(m_ovf));
`ifdef DESER_PARITY_EN
    chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
  endtask
  task automatic model_reset();
    m_cnt = 0; m_acc = 0; m_dout = '0; m_valid = 0; m_ovf = 0; m_perr = 0;
  endtask
  // One clock: drive inputs, let the edge happen, advance the frame model, compare.
  task automatic step(input logic b, input logic en, input logic sy, input logic rdy, input logic clr);
    bit done, drop, pe;
    int w;
    si = b; si_en = en; sync = sy; dout_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    done = 0; w = 0; pe = 0;
    if (sy) begin
      m_acc = en ? int'(b) : 0;
      m_cnt = en ? 1 : 0;
    end else if (en) begin
      if (m_cnt == FRAME - 1) begin
        done = 1;
        w = (FRAME == W) ? ((m_acc * 2 + int'(b)) & 255) : (m_acc & 255);
        pe = (^w[7:0]) ^ b;
        m_acc = 0; m_cnt = 0;
      end else begin
        m_acc = m_acc * 2 + int'(b);
        m_cnt++;
      end
    end
    drop = done && m_valid && !rdy;
    if (done && !drop) begin
      m_dout = w[7:0]; m_valid = 1; m_perr = pe;
    end else if (m_valid && rdy) m_valid = 0;
    m_ovf = drop || (m_ovf && !clr);
    #1;
    check_all();
  endtask
  task automatic send_frame(input logic [7:0] d, input logic rdy, input logic sy_first, input logic pflip, input bit gaps);
    for (int i = 7; i >= 0; i--) begin
      while (gaps && $urandom_range(0, 2) == 0) step(1'bx, 0, 0, rdy, 0);
      step(d[i], 1, sy_first && i == 7, rdy, 0);
    end
`ifdef DESER_PARITY_EN
    step((^d) ^ pflip, 1, 0, rdy, 0);
`else
    if (pflip) step(1'bx, 0, 0, rdy, 0);
`endif
  endtask
  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; si = 0; si_en = 0; sync = 0; dout_ready = 0; ovf_clr = 0;
    model_reset();
    #12;
    check_all();
    rst_n = 1'b1;
    // basic word with bit_cnt trace
    send_frame(8'hAF, 1, 1, 0, 0);
    chk("basic_dout", 32'(dout), 32'hAF);
    step(0, 0, 0, 1, 0);
    chk("basic_pulse_end", 32'(dout_valid), 32'h0);
    // back-pressure and overflow
    send_frame(8'hAF, 0, 0, 0, 0);
    send_frame(8'h35, 0, 0, 0, 0);
    chk("bp_dout", 32'(dout), 32'hAF);
    chk("bp_ovf", 32'(ovf), 32'h1);
    step(0, 0, 0, 1, 1);
    chk("bp_clr", 32'({ovf, dout_valid}), 32'h0);
    // back-to-back with no bubble
    send_frame(8'hAF, 1, 0, 0, 0);
    send_frame(8'h35, 1, 0, 0, 0);
    send_frame(8'hFF, 1, 0, 0, 0);
    chk("b2b_ovf", 32'(ovf), 32'h0);
    // resync discards stale bits
    step(1, 1, 0, 1, 0); step(1, 1, 0, 1, 0); step(0, 1, 0, 1, 0);
    send_frame(8'hAF, 1, 1, 0, 0);
    chk("resync_dout", 32'(dout), 32'hAF);
    step(1, 1, 0, 1, 0); step(0, 1, 0, 1, 0); step(0, 1, 0, 1, 0);
    send_frame(8'hAF, 1, 1, 0, 1);
    chk("gapped_dout", 32'(dout), 32'hAF);
    // asynchronous reset mid-word
    for (int i = 0; i < 5; i++) step(1'($urandom_range(0, 1)), 1, i == 0, 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    #1 rst_n = 1'b1;
    send_frame(8'h5A, 1, 0, 0, 0);
    chk("post_reset_dout", 32'(dout), 32'h5A);
`ifdef DESER_PARITY_EN
    send_frame(8'hAF, 1, 1, 0, 0);
    chk("par_ok", 32'({dout, parity_err}), 32'h15E);
    send_frame(8'hAF, 1, 1, 1, 0);
    chk("par_err", 32'({dout, parity_err}), 32'h15F);
`endif
    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic en;
      en = ($urandom_range(0, 3) != 0);
      step(en ? 1'($urandom_range(0, 1)) : 1'bx, en, $urandom_range(0, 15) == 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
